// File: rtl/entrada_digitos_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_digitos_if : key-code input and MM:SS entry outputs of entrada_digitos
// Revision: 1.0
// ---------------------------------------------------------------------------
interface entrada_digitos_if;
  logic [3:0] BCD;
  logic       dado_valido;
  logic       enablen;
  logic       limpa;
  logic [3:0] min_dez;
  logic [3:0] min_uni;
  logic [3:0] seg_dez;
  logic [3:0] seg_uni;
  logic [2:0] num_digitos;
  logic       cheio;
  logic       digito_aceito;

  modport slave (
    input  BCD, dado_valido, enablen, limpa,
    output min_dez, min_uni, seg_dez, seg_uni, num_digitos, cheio, digito_aceito
  );

  modport master (
    output BCD, dado_valido, enablen, limpa,
    input  min_dez, min_uni, seg_dez, seg_uni, num_digitos, cheio, digito_aceito
  );
endinterface
`default_nettype wire

// File: rtl/entrada_digitos.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_digitos : debounces keypad BCD codes and shifts one digit per press
//                   into a 4-digit MM:SS entry register
// Revision: 1.0
// ---------------------------------------------------------------------------
module entrada_digitos #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              clearn,
  entrada_digitos_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic [15:0]      digits_q, digits_d;
  logic [2:0]       num_q, num_d;
  logic             aceito_q, aceito_d;
  logic             press;

  // Codes above 9 are treated exactly like an idle keypad.
  assign press = bus.dado_valido && (bus.BCD <= 4'd9);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    digits_d = digits_q;
    num_d    = num_q;
    aceito_d = 1'b0;

    if (bus.limpa) begin
      digits_d = 16'h0000;
      num_d    = 3'd0;
      cnt_d    = '0;
      state_d  = bus.dado_valido ? WAIT_RELEASE : IDLE;
    end else if (bus.enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            cap_d   = bus.BCD;
            cnt_d   = CNT_ONE;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (press && (bus.BCD == cap_q)) begin
            if (cnt_q == CNT_LAST) begin
              state_d = WAIT_RELEASE;
              cnt_d   = '0;
              // A full register swallows the press but still waits for release.
              if (num_q != 3'd4) begin
                digits_d = {digits_q[11:0], bus.BCD};
                num_d    = num_q + 3'd1;
                aceito_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (press) begin
            cap_d = bus.BCD;
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (press) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= 4'd0;
      digits_q <= 16'h0000;
      num_q    <= 3'd0;
      aceito_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      digits_q <= digits_d;
      num_q    <= num_d;
      aceito_q <= aceito_d;
    end
  end

  assign bus.min_dez       = digits_q[15:12];
  assign bus.min_uni       = digits_q[11:8];
  assign bus.seg_dez       = digits_q[7:4];
  assign bus.seg_uni       = digits_q[3:0];
  assign bus.num_digitos   = num_q;
  assign bus.cheio         = (num_q == 3'd4);
  assign bus.digito_aceito = aceito_q;

endmodule
`default_nettype wire
